// File: rtl/dm_port_arbiter_pkg.sv
// Shared constants and types for the data-memory port arbiter.
// Holds the memory geometry, legal byte-enable encodings and request/response records.
package dm_port_arbiter_pkg;

  localparam int DM_WORDS  = 1024;
  localparam int DM_IDX_W  = 10;
  localparam int NUM_PORTS = 2;

  localparam logic [3:0] BE_B0 = 4'b0001;
  localparam logic [3:0] BE_B1 = 4'b0010;
  localparam logic [3:0] BE_B2 = 4'b0100;
  localparam logic [3:0] BE_B3 = 4'b1000;
  localparam logic [3:0] BE_H0 = 4'b0011;
  localparam logic [3:0] BE_H1 = 4'b1100;
  localparam logic [3:0] BE_W  = 4'b1111;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

  typedef struct packed {
    logic        valid;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } dm_req_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] rdata;
    logic        err;
  } dm_rsp_t;

  // Byte lanes with be set come from wdata, the rest keep the current memory word.
  function automatic logic [31:0] merge_lanes(input logic [31:0] wdata,
                                              input logic [31:0] old_word,
                                              input logic [3:0]  be);
    logic [31:0] merged;
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = be[i] ? wdata[8*i +: 8] : old_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dm_be_check.sv
// Combinational legality check for one request: range, byte-enable encoding
// and byte-enable/address alignment.
module dm_be_check
  import dm_port_arbiter_pkg::*;
#(
  parameter int MEM_WORDS = DM_WORDS,
  parameter int IDX_W     = DM_IDX_W
) (
  input  logic [31:0] addr,
  input  logic [3:0]  be,
  input  logic        we,
  output logic        err
);

  localparam logic [31:0] WORD_LIMIT = 32'(MEM_WORDS);

  logic out_of_range;
  logic be_bad;

  // The limit compare only matters if MEM_WORDS is not a power of two.
  assign out_of_range = (|addr[31:IDX_W+2]) | ({2'b00, addr[31:2]} >= WORD_LIMIT);

  always_comb begin
    be_bad = 1'b0;
    case (be)
      BE_B0:   be_bad = (addr[1:0] != 2'd0);
      BE_B1:   be_bad = (addr[1:0] != 2'd1);
      BE_B2:   be_bad = (addr[1:0] != 2'd2);
      BE_B3:   be_bad = (addr[1:0] != 2'd3);
      BE_H0:   be_bad = (addr[1:0] != 2'd0);
      BE_H1:   be_bad = (addr[1:0] != 2'd2);
      BE_W:    be_bad = (addr[1:0] != 2'd0);
      default: be_bad = 1'b1;
    endcase
  end

  // Reads ignore be entirely; a misaligned read returns the containing word.
  assign err = out_of_range | (we & be_bad);

endmodule

// File: rtl/dm_port_arbiter.sv
// Round-robin two-port arbiter in front of the word-only data memory, with
// same-cycle read-modify-write for sub-word stores and a registered response.
module dm_port_arbiter
  import dm_port_arbiter_pkg::*;
#(
  parameter int MEM_WORDS = DM_WORDS,
  parameter int IDX_W     = DM_IDX_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic        req0_we,
  input  logic [31:0] req0_addr,
  input  logic [3:0]  req0_be,
  input  logic [31:0] req0_wdata,
  output logic        req0_ready,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_rdata,
  output logic        rsp0_err,
  input  logic        req1_valid,
  input  logic        req1_we,
  input  logic [31:0] req1_addr,
  input  logic [3:0]  req1_be,
  input  logic [31:0] req1_wdata,
  output logic        req1_ready,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_rdata,
  output logic        rsp1_err,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  dm_req_t              req [NUM_PORTS];
  logic [NUM_PORTS-1:0] err;
  logic [NUM_PORTS-1:0] gnt;
  port_e                last_grant_reg;
  port_e                last_grant_next;
  port_e                sel_port;
  dm_req_t              sel;
  logic                 sel_err;

  assign req[0] = '{req0_valid, req0_we, req0_addr, req0_be, req0_wdata};
  assign req[1] = '{req1_valid, req1_we, req1_addr, req1_be, req1_wdata};

  // Both legality results exist before arbitration so the grant path stays shallow.
  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      dm_rsp_t rsp_reg;

      dm_be_check #(
        .MEM_WORDS(MEM_WORDS),
        .IDX_W    (IDX_W)
      ) u_be_check (
        .addr(req[gi].addr),
        .be  (req[gi].be),
        .we  (req[gi].we),
        .err (err[gi])
      );

      always_ff @(posedge clk) begin
        if (reset) begin
          rsp_reg <= '0;
        end else begin
          rsp_reg.valid <= gnt[gi];
          if (gnt[gi]) begin
            rsp_reg.rdata <= err[gi] ? 32'd0 : mem_rdata;
            rsp_reg.err   <= err[gi];
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_reg <= PORT1;
    end else begin
      last_grant_reg <= last_grant_next;
    end
  end

  // A grant during reset would be lost, so none is issued.
  always_comb begin
    gnt             = '0;
    last_grant_next = last_grant_reg;
    if (!reset) begin
      if (req[0].valid && (!req[1].valid || last_grant_reg == PORT1)) begin
        gnt[0] = 1'b1;
      end else if (req[1].valid) begin
        gnt[1] = 1'b1;
      end
    end
    if (gnt[0]) begin
      last_grant_next = PORT0;
    end else if (gnt[1]) begin
      last_grant_next = PORT1;
    end
  end

  always_comb begin
    sel_port  = gnt[1] ? PORT1 : PORT0;
    sel       = req[sel_port];
    sel_err   = err[sel_port];
    mem_addr  = {sel.addr[31:2], 2'b00};
    mem_wdata = merge_lanes(sel.wdata, mem_rdata, sel.be);
    mem_we    = (|gnt) & sel.valid & sel.we & ~sel_err;
  end

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];

  assign rsp0_valid = g_port[0].rsp_reg.valid;
  assign rsp0_rdata = g_port[0].rsp_reg.rdata;
  assign rsp0_err   = g_port[0].rsp_reg.err;
  assign rsp1_valid = g_port[1].rsp_reg.valid;
  assign rsp1_rdata = g_port[1].rsp_reg.rdata;
  assign rsp1_err   = g_port[1].rsp_reg.err;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Self-checking bench for dm_port_arbiter: directed scenarios plus randomized
// traffic checked against a word-array memory model and round-robin rules.
module tb_dm_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_we, req0_ready, rsp0_valid, rsp0_err;
  logic [31:0] req0_addr, req0_wdata, rsp0_rdata;
  logic [3:0]  req0_be;
  logic        req1_valid, req1_we, req1_ready, rsp1_valid, rsp1_err;
  logic [31:0] req1_addr, req1_wdata, rsp1_rdata;
  logic [3:0]  req1_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;
  logic        mem_clr;

  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  dm_port_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req0_valid(req0_valid),
    .req0_we   (req0_we),
    .req0_addr (req0_addr),
    .req0_be   (req0_be),
    .req0_wdata(req0_wdata),
    .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid),
    .rsp0_rdata(rsp0_rdata),
    .rsp0_err  (rsp0_err),
    .req1_valid(req1_valid),
    .req1_we   (req1_we),
    .req1_addr (req1_addr),
    .req1_be   (req1_be),
    .req1_wdata(req1_wdata),
    .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid),
    .rsp1_rdata(rsp1_rdata),
    .rsp1_err  (rsp1_err),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Word-only memory attached to the DUT: combinational read, write at the edge.
  assign mem_rdata = mem[mem_addr[11:2]];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'd0;
    end else if (mem_we) begin
      mem[mem_addr[11:2]] <= mem_wdata;
    end
  end

  // Reference rules: legality from counting set enables and their lowest lane.
  function automatic bit exp_err(input bit we, input logic [31:0] addr, input logic [3:0] be);
    int n;
    int lo;
    if (addr >= 32'h0000_1000) return 1'b1;
    if (!we) return 1'b0;
    n  = $countones(be);
    lo = 0;
    for (int i = 3; i >= 0; i--) if (be[i]) lo = i;
    case (n)
      1: return lo != int'(addr[1:0]);
      2: return !((be == 4'b0011 || be == 4'b1100) && lo == int'(addr[1:0]));
      4: return addr[1:0] != 2'd0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] exp_merge(input logic [31:0] old_word, input logic [31:0] wd,
                                            input logic [3:0] be);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (wd & mask) | (old_word & ~mask);
  endfunction

  task automatic set_req(input int p, input bit v, input bit we, input logic [31:0] a,
                         input logic [3:0] be, input logic [31:0] wd);
    if (p == 0) begin
      req0_valid = v; req0_we = we; req0_addr = a; req0_be = be; req0_wdata = wd;
    end else begin
      req1_valid = v; req1_we = we; req1_addr = a; req1_be = be; req1_wdata = wd;
    end
  endtask

  task automatic idle();
    set_req(0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    set_req(1, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    tick();
    checks++; if (rsp0_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp0_valid: got %b expected 0", rsp0_valid); end
    checks++; if (rsp1_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp1_valid: got %b expected 0", rsp1_valid); end
    checks++; if (rsp0_rdata !== 32'd0) begin errors++; $display("FAIL reset_rsp0_rdata: got %h expected 0", rsp0_rdata); end
    checks++; if (rsp1_rdata !== 32'd0) begin errors++; $display("FAIL reset_rsp1_rdata: got %h expected 0", rsp1_rdata); end
    checks++; if ({rsp0_err, rsp1_err} !== 2'b00) begin errors++; $display("FAIL reset_rsp_err: got %b expected 00", {rsp0_err, rsp1_err}); end
    set_req(0, 1'b1, 1'b1, 32'h40, 4'hF, 32'hCAFE0000);
    #1;
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL reset_ready0: got %b expected 0", req0_ready); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b expected 0", mem_we); end
    idle();
    reset = 1'b0;
    $display("reset: done");
  endtask

  task automatic test_single_write();
    set_req(0, 1'b1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL sw_ready: got %b expected 10", {req0_ready, req1_ready}); end
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL sw_mem_we: got %b expected 1", mem_we); end
    checks++; if (mem_addr !== 32'h10) begin errors++; $display("FAIL sw_mem_addr: got %h expected 00000010", mem_addr); end
    checks++; if (mem_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_mem_wdata: got %h expected deadbeef", mem_wdata); end
    ref_mem[4] = 32'hDEADBEEF;
    tick();
    idle();
    checks++; if ({rsp0_valid, rsp0_err, rsp1_valid} !== 3'b100) begin errors++; $display("FAIL sw_rsp: got v/err/v1 %b expected 100", {rsp0_valid, rsp0_err, rsp1_valid}); end
    set_req(0, 1'b1, 1'b0, 32'h10, 4'h0, 32'd0);
    #1;
    tick();
    idle();
    checks++; if (rsp0_rdata !== ref_mem[4]) begin errors++; $display("FAIL sw_readback: got %h expected %h", rsp0_rdata, ref_mem[4]); end
    $display("single_write: port0 wrote 0x10 = deadbeef and read it back");
  endtask

  task automatic test_merge();
    set_req(0, 1'b1, 1'b1, 32'h20, 4'hF, 32'h11223344);
    ref_mem[8] = 32'h11223344;
    #1;
    tick();
    set_req(0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    set_req(1, 1'b1, 1'b1, 32'h21, 4'b0010, 32'h0000AA00);
    #1;
    checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL merge_ready1: got %b expected 1", req1_ready); end
    checks++; if (mem_wdata !== 32'h1122AA44) begin errors++; $display("FAIL merge_wdata: got %h expected 1122aa44", mem_wdata); end
    checks++; if (mem_addr !== 32'h20) begin errors++; $display("FAIL merge_addr: got %h expected 00000020", mem_addr); end
    tick();
    idle();
    ref_mem[8] = 32'h1122AA44;
    checks++; if (rsp1_valid !== 1'b1 || rsp1_rdata !== 32'h11223344) begin errors++; $display("FAIL merge_rsp1: got v=%b %h expected v=1 11223344", rsp1_valid, rsp1_rdata); end
    $display("merge: port1 byte store into 0x21");
  endtask

  task automatic test_round_robin();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_req(0, 1'b1, 1'b0, 32'h0, 4'h0, 32'd0);
    set_req(1, 1'b1, 1'b0, 32'h4, 4'h0, 32'd0);
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (req0_ready !== (c % 2 == 0) || req1_ready !== (c % 2 == 1)) begin errors++; $display("FAIL rr_ready_c%0d: got %b%b expected %b%b", c, req0_ready, req1_ready, c % 2 == 0, c % 2 == 1); end
      tick();
      checks++; if (rsp0_valid !== (c % 2 == 0) || rsp1_valid !== (c % 2 == 1)) begin errors++; $display("FAIL rr_rsp_c%0d: got %b%b expected %b%b", c, rsp0_valid, rsp1_valid, c % 2 == 0, c % 2 == 1); end
      $display("round_robin: cycle %0d granted port %0d", c, c % 2);
    end
    idle();
  endtask

  task automatic test_errors();
    logic [31:0] a [2];
    logic [3:0]  b [2];
    a[0] = 32'h2;    b[0] = 4'b0011;
    a[1] = 32'h1000; b[1] = 4'b1111;
    for (int k = 0; k < 2; k++) begin
      set_req(0, 1'b1, 1'b1, a[k], b[k], 32'h99999999);
      #1;
      checks++; if (req0_ready !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL err_grant_%0d: got ready=%b we=%b expected ready=1 we=0", k, req0_ready, mem_we); end
      tick();
      idle();
      checks++; if (rsp0_valid !== 1'b1 || rsp0_err !== 1'b1 || rsp0_rdata !== 32'd0) begin errors++; $display("FAIL err_rsp_%0d: got v=%b err=%b %h expected v=1 err=1 0", k, rsp0_valid, rsp0_err, rsp0_rdata); end
      $display("errors: port0 rejected write to %h be %b", a[k], b[k]);
    end
    set_req(0, 1'b1, 1'b0, 32'h0, 4'h0, 32'd0);
    #1;
    tick();
    idle();
    checks++; if (rsp0_rdata !== ref_mem[0]) begin errors++; $display("FAIL err_mem_unchanged: got %h expected %h", rsp0_rdata, ref_mem[0]); end
  endtask

  task automatic test_raw();
    set_req(0, 1'b1, 1'b1, 32'h8, 4'hF, 32'h5);
    #1;
    tick();
    ref_mem[2] = 32'h5;
    set_req(0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    set_req(1, 1'b1, 1'b0, 32'h8, 4'h0, 32'd0);
    #1;
    checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL raw_ready1: got %b expected 1", req1_ready); end
    tick();
    idle();
    checks++; if (rsp1_valid !== 1'b1 || rsp1_rdata !== 32'h5) begin errors++; $display("FAIL raw_rdata: got v=%b %h expected v=1 00000005", rsp1_valid, rsp1_rdata); end
    $display("raw: port1 read 0x8 right after port0 wrote it");
  endtask

  task automatic test_reset_mid();
    set_req(1, 1'b1, 1'b0, 32'h0, 4'h0, 32'd0);
    #1;
    tick();
    idle();
    reset = 1'b1;
    set_req(0, 1'b1, 1'b1, 32'h30, 4'hF, 32'h12345678);
    #1;
    checks++; if ({req0_ready, req1_ready, mem_we} !== 3'b000) begin errors++; $display("FAIL rstmid_grant: got rdy0/rdy1/we %b expected 000", {req0_ready, req1_ready, mem_we}); end
    tick();
    checks++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin errors++; $display("FAIL rstmid_rsp: got %b expected 00", {rsp0_valid, rsp1_valid}); end
    reset = 1'b0;
    #1;
    checks++; if (req0_ready !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'h12345678) begin errors++; $display("FAIL rstmid_reissue: got rdy=%b we=%b %h expected 1 1 12345678", req0_ready, mem_we, mem_wdata); end
    tick();
    idle();
    checks++; if (rsp0_valid !== 1'b1 || rsp0_err !== 1'b0 || rsp0_rdata !== ref_mem[12]) begin errors++; $display("FAIL rstmid_rsp0: got v=%b err=%b %h expected 1 0 %h", rsp0_valid, rsp0_err, rsp0_rdata, ref_mem[12]); end
    ref_mem[12] = 32'h12345678;
    $display("reset_mid: dropped write re-issued after reset");
  endtask

  task automatic test_random();
    bit          pv  [2];
    bit          pwe [2];
    logic [31:0] pa  [2];
    logic [3:0]  pbe [2];
    logic [31:0] pwd [2];
    int          model_last;
    int          g;
    int          kind;
    bit          e;
    logic [31:0] old_word;
    logic [31:0] new_word;
    logic [31:0] exp_addr;
    reset = 1'b1;
    idle();
    tick();
    reset = 1'b0;
    model_last = 1;
    pv[0] = 1'b0;
    pv[1] = 1'b0;
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pv[p] && $urandom_range(0, 99) < 65) begin
          pv[p]  = 1'b1;
          pwe[p] = 1'($urandom_range(0, 1));
          pwd[p] = $urandom;
          pa[p]  = {24'd0, 8'($urandom_range(0, 255))};
          if ($urandom_range(0, 9) == 0) pa[p] = pa[p] | (32'h1000 << $urandom_range(0, 19));
          kind = $urandom_range(0, 3);
          case (kind)
            0: pbe[p] = 4'b0001 << pa[p][1:0];
            1: begin pa[p][0] = 1'b0; pbe[p] = pa[p][1] ? 4'b1100 : 4'b0011; end
            2: begin pa[p][1:0] = 2'b00; pbe[p] = 4'b1111; end
            default: pbe[p] = 4'($urandom_range(0, 15));
          endcase
        end
        set_req(p, pv[p], pwe[p], pa[p], pbe[p], pwd[p]);
      end
      g = -1;
      if (pv[0] && pv[1]) g = (model_last == 1) ? 0 : 1;
      else if (pv[0]) g = 0;
      else if (pv[1]) g = 1;
      #1;
      checks++; if (req0_ready !== (g == 0) || req1_ready !== (g == 1)) begin errors++; $display("FAIL rand_ready_c%0d: got %b%b expected port %0d", c, req0_ready, req1_ready, g); end
      e = 1'b0;
      old_word = 32'd0;
      if (g >= 0) begin
        e = exp_err(pwe[g], pa[g], pbe[g]);
        old_word = e ? 32'd0 : ref_mem[pa[g][11:2]];
        checks++; if (mem_we !== (pwe[g] && !e)) begin errors++; $display("FAIL rand_mem_we_c%0d: got %b expected %b", c, mem_we, pwe[g] && !e); end
        if (pwe[g] && !e) begin
          new_word = exp_merge(old_word, pwd[g], pbe[g]);
          exp_addr = pa[g] & ~32'd3;
          checks++; if (mem_addr !== exp_addr || mem_wdata !== new_word) begin errors++; $display("FAIL rand_mem_wr_c%0d: got %h=%h expected %h=%h", c, mem_addr, mem_wdata, exp_addr, new_word); end
          ref_mem[pa[g][11:2]] = new_word;
        end
        model_last = g;
        pv[g] = 1'b0;
        $display("random: cycle %0d port %0d %s addr %h be %b err %0d", c, g, pwe[g] ? "write" : "read", pa[g], pbe[g], e);
      end
      tick();
      checks++; if (rsp0_valid !== (g == 0) || rsp1_valid !== (g == 1)) begin errors++; $display("FAIL rand_rsp_valid_c%0d: got %b%b expected port %0d", c, rsp0_valid, rsp1_valid, g); end
      if (g == 0) begin
        checks++; if (rsp0_rdata !== old_word || rsp0_err !== e) begin errors++; $display("FAIL rand_rsp0_c%0d: got %h err=%b expected %h err=%b", c, rsp0_rdata, rsp0_err, old_word, e); end
      end else if (g == 1) begin
        checks++; if (rsp1_rdata !== old_word || rsp1_err !== e) begin errors++; $display("FAIL rand_rsp1_c%0d: got %h err=%b expected %h err=%b", c, rsp1_rdata, rsp1_err, old_word, e); end
      end
    end
    idle();
  endtask

  initial begin
    reset   = 1'b1;
    mem_clr = 1'b1;
    idle();
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'd0;
    @(negedge clk);
    mem_clr = 1'b0;
    test_reset();
    test_single_write();
    test_merge();
    test_round_robin();
    test_errors();
    test_raw();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
